// File: rtl/spi_dec_subnode.sv
// SPI responder for the decryption path: receives ciphertext then key on sdi,
// presents them in parallel, then serialises the recovered plaintext on sdo.
module spi_dec_subnode #(
  parameter int unsigned nk = 8,
  parameter int unsigned nb = 4,
  parameter int unsigned nr = 14
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sdi,
  input  logic [32*nb-1:0]  from_dec_msg,
  output logic              sdo,
  output logic [32*nb-1:0]  to_dec_cipher,
  output logic [32*nk-1:0]  to_dec_key,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NKEY = 32 * nk;
  localparam int unsigned NOUT = 32 * nb;
  localparam int unsigned NIN  = NOUT + NKEY;
  localparam int unsigned CW   = $clog2(NIN);
  localparam logic [CW-1:0] LastRx = CW'(NIN - 1);
  localparam logic [CW-1:0] LastTx = CW'(NOUT - 1);

  // The round count only travels with the parameter set; reject a meaningless value.
  if (nr == 0) begin : g_nr_check
    $error("spi_dec_subnode: nr must be nonzero");
  end

  typedef enum logic [2:0] {StIdle, StRx, StCapture, StTx, StDone} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NIN-2:0]      rx_q, rx_d;
  logic [NOUT-2:0]     tx_q, tx_d;
  logic                sdo_d, busy_d, done_d;
  logic [NOUT-1:0]     cipher_d;
  logic [NKEY-1:0]     key_d;
  logic [NIN-1:0]      frame;

  // The bit arriving this edge completes the frame together with the stored bits.
  assign frame = {rx_q, sdi};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    sdo_d    = 1'b0;
    done_d   = 1'b0;
    cipher_d = to_dec_cipher;
    key_d    = to_dec_key;
    unique case (state_q)
      StIdle: begin
        if (!cs) begin
          rx_d    = frame[NIN-2:0];
          cnt_d   = CW'(1);
          state_d = StRx;
        end
      end
      StRx: begin
        if (cs) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          rx_d  = frame[NIN-2:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastRx) begin
            cipher_d = frame[NIN-1 -: NOUT];
            key_d    = frame[NKEY-1:0];
            cnt_d    = '0;
            state_d  = StCapture;
          end
        end
      end
      StCapture: begin
        if (cs) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          tx_d    = from_dec_msg[NOUT-2:0];
          sdo_d   = from_dec_msg[NOUT-1];
          cnt_d   = '0;
          state_d = StTx;
        end
      end
      StTx: begin
        if (cs) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == LastTx) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          sdo_d = tx_q[NOUT-2];
          tx_d  = {tx_q[NOUT-3:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        if (cs) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == StRx) || (state_d == StCapture) || (state_d == StTx);
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      sdo           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      to_dec_cipher <= '0;
      to_dec_key    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      sdo           <= sdo_d;
      busy          <= busy_d;
      done          <= done_d;
      to_dec_cipher <= cipher_d;
      to_dec_key    <= key_d;
    end
  end

endmodule

// File: tb/tb_spi_dec_subnode.sv
// Directed bench for spi_dec_subnode; expected sdo bits are queued when a
// transaction is launched and popped as the responder shifts them out.
module tb_spi_dec_subnode;

  localparam int NK   = 8;
  localparam int NB   = 4;
  localparam int NIN  = 32 * NB + 32 * NK;
  localparam int NOUT = 32 * NB;

  logic              in_clk = 1'b0;
  logic              rst;
  logic              cs;
  logic              sdi;
  logic [NOUT-1:0]   from_dec_msg;
  logic              sdo;
  logic [NOUT-1:0]   to_dec_cipher;
  logic [32*NK-1:0]  to_dec_key;
  logic              busy;
  logic              done;

  spi_dec_subnode #(.nk(NK), .nb(NB), .nr(14)) dut (
    .in_clk        (in_clk),
    .rst           (rst),
    .cs            (cs),
    .sdi           (sdi),
    .from_dec_msg  (from_dec_msg),
    .sdo           (sdo),
    .to_dec_cipher (to_dec_cipher),
    .to_dec_key    (to_dec_key),
    .busy          (busy),
    .done          (done)
  );

  always #5 in_clk = ~in_clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];

  localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the rising edge, then sample 1ns past the next one.
  task automatic step(input logic c, input logic d);
    cs  = c;
    sdi = d;
    @(posedge in_clk);
    #1;
  endtask

  task automatic send_bits(input logic [383:0] f, input int n);
    for (int i = 0; i < n; i++) step(1'b0, f[383-i]);
  endtask

  task automatic run_txn(input logic [127:0] c, input logic [255:0] k, input logic [127:0] m);
    logic [127:0] got;
    logic         exp_b;
    logic         sdo_acc;
    int           pulses;
    from_dec_msg = m;
    for (int i = 127; i >= 0; i--) exp_q.push_back(m[i]);
    send_bits({c, k}, NIN);
    check("rx_cipher", to_dec_cipher, c);
    check("rx_key", to_dec_key, k);
    check("rx_busy", busy, 1);
    got = '0;
    for (int e = 0; e < NOUT; e++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      if (exp_q.size() == 0) begin
        check("tx_queue_empty", 1, 0);
        exp_b = 1'b0;
      end else begin
        exp_b = exp_q.pop_front();
      end
      check("tx_bit", sdo, exp_b);
      got = {got[126:0], sdo};
      if (e == NOUT - 1) check("tx_done_early", done, 0);
    end
    check("tx_word", got, m);
    step(1'b0, 1'b1);
    check("done_pulse", done, 1);
    check("done_sdo", sdo, 0);
    check("done_busy", busy, 0);
    pulses  = 0;
    sdo_acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'(i % 2));
      pulses  += int'(done);
      sdo_acc |= sdo;
    end
    check("hold_done", pulses, 0);
    check("hold_sdo", sdo_acc, 0);
    step(1'b1, 1'b0);
    check("release_busy", busy, 0);
    check("release_done", done, 0);
  endtask

  initial begin
    logic [383:0] junk;
    logic [127:0] c2;
    logic [127:0] m2;
    logic [255:0] k2;

    rst = 1'b1;
    from_dec_msg = '0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_sdo", sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cipher", to_dec_cipher, 0);
    check("rst_key", to_dec_key, 0);
    rst = 1'b0;
    step(1'b1, 1'b0);
    check("idle_busy", busy, 0);

    run_txn(CT, KEY, PT);

    // Abort mid-frame: parallel outputs must keep the earlier values.
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_bits(junk, 200);
    check("abort_busy_before", busy, 1);
    step(1'b1, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_cipher", to_dec_cipher, CT);
    check("abort_key", to_dec_key, KEY);

    // Abort on the edge that would complete the frame.
    send_bits(junk, NIN - 1);
    step(1'b1, junk[0]);
    check("late_abort_busy", busy, 0);
    check("late_abort_cipher", to_dec_cipher, CT);
    check("late_abort_key", to_dec_key, KEY);
    check("late_abort_done", done, 0);

    c2 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    m2 = {$urandom, $urandom, $urandom, $urandom};
    run_txn(c2, k2, m2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_dec_subnode.md
Name: spi_dec_subnode

Overview:
SPI responder for the decryption path, the serial counterpart to the encryption-side master/subnode link. It deserialises a ciphertext block, then a key, from `sdi`, and presents both in parallel to the decryption and key-expansion cores. It then captures the recovered plaintext and serialises it back on `sdo`. The block runs on the SPI clock that the master drives, so it has a single clock domain.

Parameters:
- `nk`, 8, key length in 32-bit words; key width is 32*nk.
- `nb`, 4, block length in 32-bit words; block width is 32*nb.
- `nr`, 14, round count. It is passed through for consistency and is unused internally.

Ports:
- `in_clk`  in  1  SPI clock from the master. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cs`  in  1  chip select, active low.
- `sdi`  in  1  serial data in, MSB first.
- `from_dec_msg`  in  32*nb  plaintext from the decryption core.
- `sdo`  out  1  serial data out, MSB first.
- `to_dec_cipher`  out  32*nb  ciphertext presented to the decryption core.
- `to_dec_key`  out  32*nk  key presented to key expansion.
- `busy`  out  1  high in RX, CAPTURE and TX.
- `done`  out  1  one-cycle pulse when the plaintext has been fully shifted out.

Behaviour:
- Constants:
  - NIN = 32*nb + 32*nk (384 at defaults).
  - NOUT = 32*nb (128 at defaults).
  - Bit counter width is clog2(NIN).
- Reset (`rst`=1 at an edge):
  - state goes to IDLE and the counter to 0.
  - `sdo`, `busy`, `done`, `to_dec_cipher`, `to_dec_key` and all shift registers go to 0.
  - Reset has priority over `cs` and over any state.
- States: IDLE, RX, CAPTURE, TX, DONE.
- IDLE:
  - With `cs`=0, shift `sdi` into the receive register LSB and set the counter to 1.
  - Go to RX, or go directly to CAPTURE when NIN=1 (degenerate case, not required).
  - With `cs`=1, stay in IDLE.
- RX:
  - Each edge with `cs`=0 shifts `sdi` in and increments the counter.
  - On the edge that shifts bit NIN, latch the full frame and go to CAPTURE:
    - `to_dec_cipher` takes frame[NIN-1 : 32*nk], i.e. the first 32*nb bits received.
    - `to_dec_key` takes frame[32*nk-1 : 0].
- CAPTURE: lasts exactly one cycle, which gives the combinational decryptor one cycle to settle. At that edge:
  - the transmit register loads `from_dec_msg`;
  - `sdo` takes `from_dec_msg`[NOUT-1];
  - the counter is cleared and the state goes to TX.
- TX:
  - Each edge shifts the transmit register left and drives the next bit on `sdo`.
  - After NOUT-1 shifts, `sdo` has presented bits NOUT-1 down to 0. On the next edge the state goes to DONE, `sdo` goes to 0 and `done` goes to 1.
- DONE:
  - `done` is high for exactly that one cycle and then returns to 0.
  - `sdi` is ignored and `sdo` is held at 0.
  - The block stays in DONE while `cs`=0 and goes to IDLE on the first edge with `cs`=1. The master must deassert `cs` between transactions.
- Abort:
  - `cs`=1 at any edge in RX, CAPTURE or TX sends the state to IDLE and clears the counter; `sdo` goes to 0 and `busy` to 0.
  - `to_dec_cipher` and `to_dec_key` keep their previous values; they update only on a complete frame.
  - `done` is not asserted.
- `busy` is registered. It is 1 for the cycle after each edge that enters RX, CAPTURE or TX, and 0 otherwise.
- Total `cs`-low transaction length: NIN + 1 + NOUT edges to reach DONE (513 at defaults).
- Simultaneous events:
  - `rst` overrides everything.
  - `cs`=1 on the frame-completing edge is treated as an abort, and the outputs are not updated.

Test Plan:
- Reset:
  - Stimulus: assert `rst` for 2 cycles with `cs`=0 and `sdi`=1.
  - Response: `sdo`=0, `busy`=0, `done`=0, `to_dec_cipher`=0, `to_dec_key`=0, state IDLE.
- Full receive:
  - Stimulus: shift ciphertext 8ea2b7ca516745bfeafc49904b496089, then key 000102…1e1f, MSB first over 384 edges.
  - Response: after edge 384, `to_dec_cipher` and `to_dec_key` equal those values exactly and `busy`=1.
- Return path:
  - Stimulus: tie `from_dec_msg` to 00112233445566778899aabbccddeeff.
  - Response: `sdo` presents 128 bits MSB first starting at the CAPTURE edge and reconstructs that value. `done` pulses once at edge 513, then `sdo`=0.
- Abort:
  - Stimulus: raise `cs` after 200 `sdi` bits, then run a complete frame.
  - Response: state IDLE and `to_dec_*` unchanged. The following full 384-bit frame is received correctly with no residual bits.
- DONE hold:
  - Stimulus: keep `cs`=0 for 50 edges after `done`, toggling `sdi`.
  - Response: `done` asserted for exactly 1 cycle and `sdo` stays 0. Raising `cs` returns the block to IDLE, and a new transaction succeeds.
- End to end:
  - Stimulus: connect the decryption and key-expansion cores, then send the FIPS-197 AES-256 ciphertext and key.
  - Response: the serial readback on `sdo` equals plaintext 00112233445566778899aabbccddeeff.
